hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard scheduler for the 5-stage MIPS pipeline; owns the select lines of the ID-stage operand forwarding mux.
//  Keeps a shadow copy of destination info for EX and MEM.
//  Outputs: fwd_rs/fwd_rt (2'b10 = EX result, 2'b01 = MEM ALU result, 2'b00 = regfile), ID stall, EX bubble.
//  Tracks the multi-cycle divider and holds HI/LO consumers until the divide completes.
// PARAMETERS
//  DIV_CYCLES  32  cycles the divider is busy after a divide issues (>=2)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  id_valid    in   1   ID holds a real instruction
//  id_rs       in   5   rs register index of the ID instruction
//  id_rt       in   5   rt register index of the ID instruction
//  id_use_rs   in   1   ID instruction reads rs
//  id_use_rt   in   1   ID instruction reads rt
//  id_wr_en    in   1   ID instruction writes the regfile
//  id_wr_addr  in   5   destination register of the ID instruction
//  id_is_load  in   1   ID instruction is a load (result not forwardable)
//  id_is_div   in   1   ID instruction starts a divide
//  id_use_hilo in   1   ID instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
//  flush       in   1   branch/jump redirect: squash the ID instruction this cycle
//  fwd_rs      out  2   rs forwarding select
//  fwd_rt      out  2   rt forwarding select
//  stall_id    out  1   hold PC and the IF/ID register
//  bubble_ex   out  1   load a NOP into ID/EX
//  div_busy    out  1   divider is occupied
// BEHAVIOUR
//  Shadow state: ex_{wr,addr,load}, mem_{wr,addr,load}, div_cnt. All are cleared on rst, asynchronously.
//  After reset every output is 0.
//  issue = id_valid & ~stall_id & ~flush.
//  Each clock: mem_* <= ex_*. ex_* <= issue ? ID fields : 0 (a bubble has wr=0).
//  fwd_rs is combinational, evaluated for the ID instruction:
//    10 if id_use_rs & ex_wr & ~ex_load & ex_addr==id_rs & id_rs!=0;
//    else 01 if the same condition holds against mem_*;
//    else 00. EX has priority over MEM.
//  fwd_rt: same rule using id_rt / id_use_rt.
//  Register $0 is never forwarded and never causes a stall.
//  load_haz: a used source matches ex_addr or mem_addr of a stage with wr & load.
//  The regfile writes before it reads in WB, so a load needs no action once it reaches WB.
//  A load-use pair in consecutive instructions therefore stalls 2 cycles.
//  div_haz = id_valid & id_use_hilo & div_busy (id_is_div implies id_use_hilo).
//  stall_id = load_haz | div_haz; this ignores flush. bubble_ex = stall_id | flush.
//  While a hazard is active, fwd_* still reflect current matches. They are don't-care to the datapath while bubble_ex=1.
//  Divider:
//    - issue & id_is_div loads div_cnt = DIV_CYCLES.
//    - Otherwise div_cnt decrements to 0 and saturates there.
//    - div_busy = (div_cnt != 0). The HI/LO consumer issues in the cycle div_cnt reaches 0.
//  flush together with a stall: the ID instruction is dropped (bubble), stall_id still holds the PC, and no divide starts.
//  rst asserted mid-divide clears div_cnt at once; div_busy drops without waiting for a clock edge.
//  Latency: stall_id, bubble_ex and fwd_* are combinational from ID inputs and registered state; there are no added pipeline cycles.
// STRUCTURE
//  Shared package mips_defs:
//    - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_EXE=2'b10
//    - REG_ZERO=5'd0
//    - the hazard_stage_t struct {wr, addr[4:0], load}
//  Sub-module div_tracker holds the DIV_CYCLES down-counter.
//    - Inputs: clk, rst, start. Output: busy.
//  Forwarding compare and stall logic live in hazard_ctrl itself.
// TESTING
//  1 add $3 then sub using $3 next cycle -> fwd_rs=10, no stall. One cycle later, the next reader of $3 -> fwd_rs=01.
//  2 lw $5 then add $6,$5,$5 -> stall_id=1 and bubble_ex=1 for 2 cycles. Then fwd_rs=fwd_rt=00, add issues on cycle 3.
//  3 Both EX and MEM write $7, ID reads $7 -> fwd=10. A write to $0 followed by a read of $0 -> fwd=00, no stall.
//  4 div (DIV_CYCLES=4) then mflo -> stall_id=1 for 4 cycles, div_busy falls, mflo issues.
//    Also: rst pulsed mid-divide -> div_busy=0 at once.
//  5 flush during a load-use stall -> ID instruction dropped, bubble_ex=1, ex_wr=0 next cycle.
//    Also: a div under flush does not assert div_busy.
//  6 rst held with random ID inputs -> fwd_*=00, stall_id=bubble_ex=div_busy=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline hazard logic: forwarding selects,
// the hardwired zero register, and the per-stage destination record.
package mips_defs;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EXE = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic       load;
  } hazard_stage_t;

endpackage

// File: rtl/div_tracker.sv
// Occupancy counter for the multi-cycle divider: loads DIV_CYCLES on start,
// then counts down to zero and holds there.
module div_tracker #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded straight from the flop so an async reset drops busy immediately.
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage MIPS pipeline: ID-stage forwarding selects,
// load-use and HI/LO-after-divide stalls, and EX bubble insertion.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_addr,
  input  logic       id_is_load,
  input  logic       id_is_div,
  input  logic       id_use_hilo,
  input  logic       flush,
  output logic [1:0] fwd_rs,
  output logic [1:0] fwd_rt,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       div_busy
);

  hazard_stage_t ex_q, ex_d;
  hazard_stage_t mem_q, mem_d;

  logic issue;
  logic load_haz;
  logic div_haz;
  logic div_start;

  function automatic logic [1:0] fwd_sel(input logic          use_src,
                                         input logic [4:0]    src,
                                         input hazard_stage_t ex,
                                         input hazard_stage_t mem);
    if (!use_src || src == REG_ZERO) return FWD_REG;
    if (ex.wr && !ex.load && ex.addr == src) return FWD_EXE;
    if (mem.wr && !mem.load && mem.addr == src) return FWD_MEM;
    return FWD_REG;
  endfunction

  // A load result is unavailable until WB, where the write-before-read regfile covers it.
  function automatic logic load_hit(input logic          use_src,
                                    input logic [4:0]    src,
                                    input hazard_stage_t ex,
                                    input hazard_stage_t mem);
    logic hit;
    hit = 1'b0;
    if (use_src && src != REG_ZERO) begin
      hit = (ex.wr && ex.load && ex.addr == src) ||
            (mem.wr && mem.load && mem.addr == src);
    end
    return hit;
  endfunction

  always_comb begin
    fwd_rs    = fwd_sel(id_use_rs, id_rs, ex_q, mem_q);
    fwd_rt    = fwd_sel(id_use_rt, id_rt, ex_q, mem_q);
    load_haz  = load_hit(id_use_rs, id_rs, ex_q, mem_q) ||
                load_hit(id_use_rt, id_rt, ex_q, mem_q);
    div_haz   = id_valid && (id_use_hilo || id_is_div) && div_busy;
    stall_id  = load_haz || div_haz;
    bubble_ex = stall_id || flush;
    issue     = id_valid && !stall_id && !flush;
    div_start = issue && id_is_div;
  end

  always_comb begin
    mem_d = ex_q;
    ex_d  = '0;
    if (issue) begin
      ex_d.wr   = id_wr_en;
      ex_d.addr = id_wr_addr;
      ex_d.load = id_is_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  div_tracker #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_tracker (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .busy (div_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle instruction table with
// hand-computed selects/stalls, plus reset sequences around the divider.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_div, id_use_hilo;
  logic       flush;
  logic [1:0] fwd_rs, fwd_rt;
  logic       stall_id, bubble_ex, div_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_wr_en   (id_wr_en),
    .id_wr_addr (id_wr_addr),
    .id_is_load (id_is_load),
    .id_is_div  (id_is_div),
    .id_use_hilo(id_use_hilo),
    .flush      (flush),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .div_busy   (div_busy)
  );

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, wr;
    logic [4:0] wa;
    logic       ld, dv, hl, fl;
    logic [1:0] ers, ert;
    logic       est, ebu, ebz;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(string name, logic v, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic wr, logic [4:0] wa,
                              logic ld, logic dv, logic hl, logic fl,
                              logic [1:0] ers, logic [1:0] ert,
                              logic est, logic ebu, logic ebz);
    vec_t r;
    r.name = name; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.wr = wr; r.wa = wa; r.ld = ld; r.dv = dv; r.hl = hl; r.fl = fl;
    r.ers = ers; r.ert = ert; r.est = est; r.ebu = ebu; r.ebz = ebz;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0b expected=%0b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_wr_en = t.wr; id_wr_addr = t.wa; id_is_load = t.ld; id_is_div = t.dv;
    id_use_hilo = t.hl; flush = t.fl;
  endtask

  task automatic check_all_zero(input string nm, input int idx);
    chk({nm, ".fwd_rs"}, idx, fwd_rs, 2'b00);
    chk({nm, ".fwd_rt"}, idx, fwd_rt, 2'b00);
    chk({nm, ".stall"}, idx, {1'b0, stall_id}, 2'b00);
    chk({nm, ".bubble"}, idx, {1'b0, bubble_ex}, 2'b00);
    chk({nm, ".busy"}, idx, {1'b0, div_busy}, 2'b00);
  endtask

  vec_t nop;

  initial begin
    //                 name        v  rs  rt urs urt wr wa ld dv hl fl  ers    ert  st bu bz
    vecs[0]  = mk("add3",      1, 1,  2, 1, 1, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[1]  = mk("sub_ex3",   1, 3,  1, 1, 1, 1, 4, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);
    vecs[2]  = mk("or_mem3",   1, 3,  0, 1, 1, 1, 5, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    vecs[3]  = mk("lw5",       1, 1,  0, 1, 0, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[4]  = mk("use5_s1",   1, 5,  5, 1, 1, 1, 6, 0, 0, 0, 0, 2'b01, 2'b01, 1, 1, 0);
    vecs[5]  = mk("use5_s2",   1, 5,  5, 1, 1, 1, 6, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0);
    vecs[6]  = mk("use5_go",   1, 5,  5, 1, 1, 1, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[7]  = mk("add7a",     1, 1,  2, 1, 1, 1, 7, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[8]  = mk("add7b",     1, 1,  2, 1, 1, 1, 7, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[9]  = mk("use7_pri",  1, 7,  7, 1, 1, 1, 8, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0);
    vecs[10] = mk("wr0",       1, 1,  2, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[11] = mk("rd0",       1, 0,  0, 1, 1, 1, 9, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[12] = mk("lw0",       1, 1,  0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[13] = mk("rd0_ld",    1, 0,  0, 1, 1, 1, 10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[14] = mk("div",       1, 1,  2, 1, 1, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[15] = mk("mflo_s1",   1, 0,  0, 0, 0, 1, 11, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 1);
    vecs[16] = mk("mflo_s2",   1, 0,  0, 0, 0, 1, 11, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 1);
    vecs[17] = mk("mflo_s3",   1, 0,  0, 0, 0, 1, 11, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 1);
    vecs[18] = mk("mflo_s4",   1, 0,  0, 0, 0, 1, 11, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 1);
    vecs[19] = mk("mflo_go",   1, 0,  0, 0, 0, 1, 11, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[20] = mk("nop_a",     0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[21] = mk("lw12",      1, 1,  0, 1, 0, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[22] = mk("use12_fl",  1, 12, 12, 1, 1, 1, 13, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 0);
    vecs[23] = mk("rd13",      1, 13, 1, 1, 1, 1, 14, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[24] = mk("div_fl",    1, 1,  2, 1, 1, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0, 1, 0);
    vecs[25] = mk("nop_b",     0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    nop      = mk("nop",       0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    rst = 1'b1;
    drive(nop);
    #3;
    check_all_zero("reset", 0);

    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #3;
      chk({vecs[i].name, ".fwd_rs"}, i, fwd_rs, vecs[i].ers);
      chk({vecs[i].name, ".fwd_rt"}, i, fwd_rt, vecs[i].ert);
      chk({vecs[i].name, ".stall"}, i, {1'b0, stall_id}, {1'b0, vecs[i].est});
      chk({vecs[i].name, ".bubble"}, i, {1'b0, bubble_ex}, {1'b0, vecs[i].ebu});
      chk({vecs[i].name, ".busy"}, i, {1'b0, div_busy}, {1'b0, vecs[i].ebz});
      @(posedge clk); #1;
    end

    // Reset pulsed while the divider is busy: busy must drop without a clock edge.
    drive(vecs[14]);
    @(posedge clk); #1;
    drive(vecs[15]);
    #1;
    chk("middiv.busy_before", 0, {1'b0, div_busy}, 2'b01);
    chk("middiv.stall_before", 0, {1'b0, stall_id}, 2'b01);
    #1;
    rst = 1'b1;
    #1;
    chk("middiv.busy_async", 0, {1'b0, div_busy}, 2'b00);
    chk("middiv.stall_async", 0, {1'b0, stall_id}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("middiv.busy_after", 0, {1'b0, div_busy}, 2'b00);
    chk("middiv.stall_after", 0, {1'b0, stall_id}, 2'b00);
    @(posedge clk); #1;

    // Reset held with arbitrary ID traffic: everything stays quiet.
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      id_valid    = 1'($urandom);
      id_rs       = 5'($urandom);
      id_rt       = 5'($urandom);
      id_use_rs   = 1'($urandom);
      id_use_rt   = 1'($urandom);
      id_wr_en    = 1'($urandom);
      id_wr_addr  = 5'($urandom);
      id_is_load  = 1'($urandom);
      id_is_div   = 1'($urandom);
      id_use_hilo = id_is_div | 1'($urandom);
      flush       = 1'b0;
      #3;
      check_all_zero("rst_held", k);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
